// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers EX results, runs word loads/stores over dmem req/ack.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES without ack and pulses err_o.
`ifndef RW_NONE
`define RW_NONE 2'd0
`endif
`ifndef RW_ALU
`define RW_ALU 2'd1
`endif
`ifndef RW_MEM
`define RW_MEM 2'd2
`endif

module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  stall_i,
   input  logic [1:0]  rw_src_i,
   input  logic [4:0]  rw_i,
   input  logic        mem_wea_i,
   input  logic        pcwr_en_i,
   input  logic [31:0] address_i,
   input  logic [31:0] F_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i,
   output logic        stall_req_o,
   output logic [1:0]  rw_src_o,
   output logic [4:0]  rw_o,
   output logic [31:0] wb_data_o,
   output logic        pcwr_en_o,
   output logic [31:0] pc_addr_o,
   output logic        err_o
);

   localparam int unsigned DW        = 32;
   localparam int unsigned RW_W      = 5;
   localparam int unsigned SRC_W     = 2;
   localparam int unsigned MEM_STALL = 4;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state_q, state_d;
   logic [SRC_W-1:0]  lat_src_q, lat_src_d;
   logic [RW_W-1:0]   lat_rw_q, lat_rw_d;
   logic              lat_we_q, lat_we_d;
   logic [DW-1:0]     lat_addr_q, lat_addr_d;
   logic [DW-1:0]     lat_f_q, lat_f_d;
   logic              req_q, req_d;
   logic [SRC_W-1:0]  rw_src_q, rw_src_d;
   logic [RW_W-1:0]   rw_q, rw_d;
   logic [DW-1:0]     wb_data_q, wb_data_d;
   logic              pcwr_en_q, pcwr_en_d;
   logic [DW-1:0]     pc_addr_q, pc_addr_d;
   logic              err_q, err_d;
   logic              memop_c;
   logic              stall_req_c;
   logic              unused_stall_c;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   assign unused_stall_c = ^{stall_i[5], stall_i[3:0]};
   assign memop_c        = mem_wea_i | (rw_src_i == `RW_MEM);

   // Next-state, latch capture and output-register inputs; outputs default to a bubble.
   always_comb begin
      state_d     = state_q;
      lat_src_d   = lat_src_q;
      lat_rw_d    = lat_rw_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_f_d     = lat_f_q;
      req_d       = req_q;
      rw_src_d    = `RW_NONE;
      rw_d        = '0;
      wb_data_d   = '0;
      pcwr_en_d   = 1'b0;
      pc_addr_d   = '0;
      err_d       = 1'b0;
      stall_req_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (!stall_i[MEM_STALL]) begin
               if (memop_c) begin
                  lat_src_d   = rw_src_i;
                  lat_rw_d    = rw_i;
                  lat_we_d    = mem_wea_i;
                  lat_addr_d  = {address_i[DW-1:2], 2'b00};
                  lat_f_d     = F_i;
                  req_d       = 1'b1;
                  stall_req_c = 1'b1;
                  state_d     = ACCESS;
`ifdef MEM_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end else begin
                  rw_src_d  = rw_src_i;
                  rw_d      = rw_i;
                  pcwr_en_d = pcwr_en_i;
                  pc_addr_d = address_i;
                  wb_data_d = F_i;
               end
            end
         end
         ACCESS: begin
            if (dmem_ack_i) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               rw_src_d  = lat_src_q;
               rw_d      = lat_rw_q;
               wb_data_d = lat_we_q ? lat_f_q : dmem_rdata_i;
`ifdef MEM_TIMEOUT_EN
            end else if (cnt_q == CNT_LAST) begin
               // Abort: bubble out, single-cycle error pulse, release the freeze now.
               state_d = IDLE;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d       = cnt_q + CNT_W'(1);
               stall_req_c = 1'b1;
`else
            end else begin
               stall_req_c = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lat_src_q  <= `RW_NONE;
         lat_rw_q   <= '0;
         lat_we_q   <= 1'b0;
         lat_addr_q <= '0;
         lat_f_q    <= '0;
         req_q      <= 1'b0;
         rw_src_q   <= `RW_NONE;
         rw_q       <= '0;
         wb_data_q  <= '0;
         pcwr_en_q  <= 1'b0;
         pc_addr_q  <= '0;
         err_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lat_src_q  <= lat_src_d;
         lat_rw_q   <= lat_rw_d;
         lat_we_q   <= lat_we_d;
         lat_addr_q <= lat_addr_d;
         lat_f_q    <= lat_f_d;
         req_q      <= req_d;
         rw_src_q   <= rw_src_d;
         rw_q       <= rw_d;
         wb_data_q  <= wb_data_d;
         pcwr_en_q  <= pcwr_en_d;
         pc_addr_q  <= pc_addr_d;
         err_q      <= err_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign dmem_req_o   = req_q;
   assign dmem_we_o    = lat_we_q;
   assign dmem_addr_o  = lat_addr_q;
   assign dmem_wdata_o = lat_f_q;
   assign stall_req_o  = stall_req_c;
   assign rw_src_o     = rw_src_q;
   assign rw_o         = rw_q;
   assign wb_data_o    = wb_data_q;
   assign pcwr_en_o    = pcwr_en_q;
   assign pc_addr_o    = pc_addr_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage; timeout checks run when MEM_TIMEOUT_EN is defined.
`ifndef RW_NONE
`define RW_NONE 2'd0
`endif
`ifndef RW_ALU
`define RW_ALU 2'd1
`endif
`ifndef RW_MEM
`define RW_MEM 2'd2
`endif

module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  stall_i;
   logic [1:0]  rw_src_i;
   logic [4:0]  rw_i;
   logic        mem_wea_i;
   logic        pcwr_en_i;
   logic [31:0] address_i;
   logic [31:0] F_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;
   logic        stall_req_o;
   logic [1:0]  rw_src_o;
   logic [4:0]  rw_o;
   logic [31:0] wb_data_o;
   logic        pcwr_en_o;
   logic [31:0] pc_addr_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;
   int stall_cnt;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .rw_src_i     (rw_src_i),
      .rw_i         (rw_i),
      .mem_wea_i    (mem_wea_i),
      .pcwr_en_i    (pcwr_en_i),
      .address_i    (address_i),
      .F_i          (F_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_ack_i   (dmem_ack_i),
      .stall_req_o  (stall_req_o),
      .rw_src_o     (rw_src_o),
      .rw_o         (rw_o),
      .wb_data_o    (wb_data_o),
      .pcwr_en_o    (pcwr_en_o),
      .pc_addr_o    (pc_addr_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall_i   = '0;
      rw_src_i  = `RW_NONE;
      rw_i      = '0;
      mem_wea_i = 1'b0;
      pcwr_en_i = 1'b0;
      address_i = '0;
      F_i       = '0;
   endtask

   task automatic drive(input logic [1:0] src, input logic [4:0] rd, input logic we,
                        input logic [31:0] addr, input logic [31:0] f);
      rw_src_i  = src;
      rw_i      = rd;
      mem_wea_i = we;
      address_i = addr;
      F_i       = f;
   endtask

   initial begin
      rst_n        = 1'b0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = '0;
      idle_inputs();
      step();
      step();
      check_eq("rst_rw_src", 32'(rw_src_o), 32'(`RW_NONE));
      check_eq("rst_wb_data", wb_data_o, 32'h0);
      check_eq("rst_req", 32'(dmem_req_o), 32'h0);
      check_eq("rst_pc", pc_addr_o, 32'h0);
      rst_n = 1'b1;

      // ALU pass-through
      drive(`RW_ALU, 5'd5, 1'b0, 32'h0, 32'h1234_5678);
      #1;
      check_eq("alu_stall", 32'(stall_req_o), 32'h0);
      step();
      check_eq("alu_rw", 32'(rw_o), 32'd5);
      check_eq("alu_wb", wb_data_o, 32'h1234_5678);
      check_eq("alu_src", 32'(rw_src_o), 32'(`RW_ALU));
      check_eq("alu_req", 32'(dmem_req_o), 32'h0);

      // Load, ack in first ACCESS cycle
      drive(`RW_MEM, 5'd7, 1'b0, 32'h100, 32'h0);
      #1;
      check_eq("ld_stall_idle", 32'(stall_req_o), 32'h1);
      step();
      idle_inputs();
      check_eq("ld_req", 32'(dmem_req_o), 32'h1);
      check_eq("ld_addr", dmem_addr_o, 32'h100);
      check_eq("ld_we", 32'(dmem_we_o), 32'h0);
      check_eq("ld_bubble", 32'(rw_src_o), 32'(`RW_NONE));
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'hDEAD_BEEF;
      // Second load queued right behind the ack
      drive(`RW_MEM, 5'd9, 1'b0, 32'h104, 32'h0);
      step();
      dmem_ack_i = 1'b0;
      check_eq("ld_wb", wb_data_o, 32'hDEAD_BEEF);
      check_eq("ld_src", 32'(rw_src_o), 32'(`RW_MEM));
      check_eq("ld_rw", 32'(rw_o), 32'd7);
      check_eq("ld_req_drop", 32'(dmem_req_o), 32'h0);
      check_eq("b2b_stall", 32'(stall_req_o), 32'h1);
      step();
      idle_inputs();
      check_eq("b2b_req", 32'(dmem_req_o), 32'h1);
      check_eq("b2b_addr", dmem_addr_o, 32'h104);
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'h0BAD_F00D;
      step();
      dmem_ack_i = 1'b0;
      check_eq("b2b_wb", wb_data_o, 32'h0BAD_F00D);
      check_eq("b2b_rw", 32'(rw_o), 32'd9);

      // Store to unaligned address, ack after 3 wait cycles
      stall_cnt = 0;
      drive(`RW_NONE, 5'd0, 1'b1, 32'h203, 32'hA5A5_A5A5);
      #1;
      if (stall_req_o) stall_cnt++;
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         dmem_ack_i = (i == 3);
         #1;
         if (stall_req_o) stall_cnt++;
         check_eq($sformatf("st_req%0d", i), 32'(dmem_req_o), 32'h1);
         check_eq($sformatf("st_addr%0d", i), dmem_addr_o, 32'h200);
         check_eq($sformatf("st_wdata%0d", i), dmem_wdata_o, 32'hA5A5_A5A5);
         check_eq($sformatf("st_we%0d", i), 32'(dmem_we_o), 32'h1);
         step();
      end
      dmem_ack_i = 1'b0;
      check_eq("st_stall_cycles", 32'(stall_cnt), 32'd4);
      check_eq("st_req_drop", 32'(dmem_req_o), 32'h0);
      check_eq("st_wb", wb_data_o, 32'hA5A5_A5A5);
      check_eq("st_src", 32'(rw_src_o), 32'(`RW_NONE));

      // Branch under MEM stall, then released
      pcwr_en_i = 1'b1;
      address_i = 32'h40;
      stall_i   = 6'b01_0000;
      step();
      check_eq("br_stall_pcwr", 32'(pcwr_en_o), 32'h0);
      check_eq("br_stall_pc", pc_addr_o, 32'h0);
      stall_i = '0;
      step();
      check_eq("br_pcwr", 32'(pcwr_en_o), 32'h1);
      check_eq("br_pc", pc_addr_o, 32'h40);
      idle_inputs();

      // Stalled memop must not start; ack in IDLE is ignored
      drive(`RW_MEM, 5'd3, 1'b0, 32'h80, 32'h0);
      stall_i    = 6'b01_0000;
      dmem_ack_i = 1'b1;
      #1;
      check_eq("stl_memop_stall", 32'(stall_req_o), 32'h0);
      step();
      dmem_ack_i = 1'b0;
      idle_inputs();
      check_eq("stl_memop_req", 32'(dmem_req_o), 32'h0);
      check_eq("idle_ack_src", 32'(rw_src_o), 32'(`RW_NONE));

      // Reset mid-access
      drive(`RW_MEM, 5'd4, 1'b0, 32'h300, 32'h0);
      step();
      idle_inputs();
      check_eq("rstacc_req_pre", 32'(dmem_req_o), 32'h1);
      rst_n = 1'b0;
      step();
      check_eq("rstacc_req", 32'(dmem_req_o), 32'h0);
      check_eq("rstacc_addr", dmem_addr_o, 32'h0);
      rst_n        = 1'b1;
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = 32'h1111_2222;
      step();
      dmem_ack_i = 1'b0;
      check_eq("rstacc_late_wb", wb_data_o, 32'h0);
      check_eq("rstacc_late_src", 32'(rw_src_o), 32'(`RW_NONE));
      check_eq("rstacc_late_req", 32'(dmem_req_o), 32'h0);

`ifdef MEM_TIMEOUT_EN
      // No ack: abort on the 4th ACCESS cycle
      drive(`RW_MEM, 5'd6, 1'b0, 32'h400, 32'h0);
      step();
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("to_stall%0d", i), 32'(stall_req_o), (i == 3) ? 32'h0 : 32'h1);
         check_eq($sformatf("to_err%0d", i), 32'(err_o), 32'h0);
         step();
      end
      check_eq("to_err_pulse", 32'(err_o), 32'h1);
      check_eq("to_src", 32'(rw_src_o), 32'(`RW_NONE));
      check_eq("to_req", 32'(dmem_req_o), 32'h0);
      step();
      check_eq("to_err_clear", 32'(err_o), 32'h0);
`else
      check_eq("err_tied", 32'(err_o), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
